rr_mux8to1: RTL and testbench
=============================

// Module: rr_mux8to1
// PURPOSE
//  Merges eight valid/ready input channels onto one registered output channel.
//  It is the merge-side counterpart to the 1-to-8 channel fan-out: source index travels with each beat.
//  Arbitration is fair round-robin; throughput is one beat per clock.
// PARAMETERS
//  WIDTH  8  data bits per beat
// PORTS
//  clk        in   1        rising-edge clock, single domain
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   8        per-channel valid, bit i = channel i
//  in_data    in   8*WIDTH  channel i data at [i*WIDTH +: WIDTH]
//  in_ready   out  8        per-channel accept, at most one bit set (one-hot or zero)
//  out_valid  out  1        output beat present
//  out_data   out  WIDTH    output beat data
//  out_sel    out  3        index of source channel of out_data
//  out_ready  in   1        downstream accept
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, out_sel=0, ptr=7.
//    On the first arbitration after reset, channel 0 has top priority.
//  - Reset mid-operation discards any held output beat.
//  - Transfer rules:
//    - Input transfer on channel i: in_valid[i] && in_ready[i].
//    - Output transfer: out_valid && out_ready.
//  - load = !out_valid || out_ready.
//    - in_ready[g] = load && grant[g], where grant is one-hot over in_valid.
//    - in_ready is combinational from in_valid, ptr and out_ready.
//  - Grant: the first valid channel searching ptr+1, ptr+2, ... modulo 8 (7 wraps to 0).
//    - If no channel is valid, there is no grant and in_ready is 0.
//  - On input transfer from g:
//    - out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g.
//  - On output transfer with no input transfer: out_valid <= 0.
//  - Simultaneous output and input transfer: the new beat replaces the old in the same edge.
//    Back-to-back beats run with no bubble.
//  - While out_valid && !out_ready: out_data and out_sel hold stable; in_ready is all zero.
//  - Latency: one clock from input transfer to out_valid.
//  - ptr is unchanged in cycles with no input transfer.
//  - A channel dropping in_valid before being granted is legal; it simply loses its turn.
// CONFIGURATION
//  RR_MUX_PKT_LOCK_EN defined:
//    - Adds ports in_last (in, 8) and out_last (out, 1); out_last resets to 0 and is registered with out_data.
//    - After an input transfer from g with in_last[g]=0, the grant is locked to g.
//    - The lock holds even if in_valid[g] drops, and other channels are held off.
//    - The lock releases after a transfer from g with in_last[g]=1.
//    - Reset clears the lock.
//  RR_MUX_PKT_LOCK_EN undefined: no in_last/out_last ports; every beat is arbitrated independently.
// STRUCTURE
//  - Package mux_pkg: N_CH=8, SEL_W=3, function rr_pick(valid[7:0], ptr[2:0]) returning the one-hot grant.
//  - Sub-module rr_arbiter8: combinational grant from in_valid and ptr (plus lock state when enabled).
//    The parent owns ptr, the output register, and (when enabled) the lock register.
// TESTING
//  1. Reset held 2 cycles, then all in_valid=8'hFF, out_ready=1.
//     -> out_sel sequence 0,1,2,...,7,0 on consecutive cycles; no bubbles.
//  2. Only ch5 valid, data 8'hA5.
//     -> in_ready=8'h20; next cycle out_valid=1, out_data=A5, out_sel=5.
//  3. out_ready=0 with a beat held.
//     -> in_ready=0, out_data/out_sel stable 4 cycles.
//     Release out_ready -> held beat and the next beat both transfer without loss.
//  4. ptr=6, ch3 and ch7 valid. -> ch7 granted first, then ch3; wrap 7->0 verified with ch0 and ch7 valid.
//  5. Assert reset while out_valid=1, out_ready=0.
//     -> next cycle out_valid=0; the next grant goes to the lowest valid channel.
//  6. LOCK_EN: ch2 sends 3 beats (in_last=0,0,1) while ch4 is valid.
//     -> out_sel=2,2,2 then 4; a ch2 valid gap does not release the lock.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and round-robin pick function for the 8-to-1 merge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   N_CH    number of merged channels
//   SEL_W   width of a channel index
//   rr_pick one-hot grant: first valid channel after ptr, wrapping 7 -> 0
package mux_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    // Search order is ptr+1, ptr+2, ..., ptr+8 (== ptr), all modulo 8.
    // The previous winner therefore has the lowest priority next time.
    function automatic logic [N_CH-1:0] rr_pick(
        input logic [N_CH-1:0]  valid,
        input logic [SEL_W-1:0] ptr
    );
        logic [N_CH-1:0]  grant;
        logic             found;
        logic [SEL_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational round-robin grant over eight channels, with optional packet lock.
// Latency: purely combinational.
// Backpressure: none here; the parent gates the grant with its load condition.
//
// Ports:
//   in_valid  per-channel request
//   ptr       index of the last granted channel
//   lock_vld  (RR_MUX_PKT_LOCK_EN) a packet is in flight on lock_ch
//   lock_ch   (RR_MUX_PKT_LOCK_EN) channel owning the current packet
//   grant     one-hot grant, zero when nothing is eligible
// Optional feature macro: RR_MUX_PKT_LOCK_EN
module rr_arbiter8
    import mux_pkg::*;
(
    input  logic [N_CH-1:0]  in_valid,
    input  logic [SEL_W-1:0] ptr,
`ifdef RR_MUX_PKT_LOCK_EN
    input  logic             lock_vld,
    input  logic [SEL_W-1:0] lock_ch,
`endif
    output logic [N_CH-1:0]  grant
);

    always_comb begin
        grant = rr_pick(in_valid, ptr);
`ifdef RR_MUX_PKT_LOCK_EN
        // Mid-packet only the owning channel may be granted; if it has a gap
        // nobody is granted, so the packet is never interleaved.
        if (lock_vld) begin
            grant          = '0;
            grant[lock_ch] = in_valid[lock_ch];
        end
`endif
    end

endmodule

// File: rtl/rr_mux8to1.sv
// Round-robin merge of eight valid/ready channels onto one registered output.
// Latency: one clock from input transfer to out_valid; one beat per clock sustained.
// Backpressure: while out_valid && !out_ready the output holds and all in_ready are low.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     per-channel handshake (in_ready one-hot or zero)
//   in_data               channel i at [i*WIDTH +: WIDTH]
//   in_last/out_last      (RR_MUX_PKT_LOCK_EN) packet end marker
//   out_valid/out_ready   output handshake
//   out_data, out_sel     output beat and its source channel
// Optional feature macro: RR_MUX_PKT_LOCK_EN
module rr_mux8to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
`ifdef RR_MUX_PKT_LOCK_EN
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_last,
`endif
    input  logic                  out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [N_CH-1:0]  grant;
    logic             load;
    logic             xfer;
    logic [SEL_W-1:0] gsel;
    logic [WIDTH-1:0] gdata;

`ifdef RR_MUX_PKT_LOCK_EN
    logic             lock_vld;
    logic [SEL_W-1:0] lock_ch;
`endif

    rr_arbiter8 u_arb (
        .in_valid (in_valid),
        .ptr      (ptr),
`ifdef RR_MUX_PKT_LOCK_EN
        .lock_vld (lock_vld),
        .lock_ch  (lock_ch),
`endif
        .grant    (grant)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign load     = !out_valid || out_ready;
    assign in_ready = load ? grant : '0;
    // grant only ever selects a valid channel, so any ready bit is a transfer.
    assign xfer     = |in_ready;

    always_comb begin
        gsel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) gsel = SEL_W'(i);
        end
    end

    assign gdata = in_data[int'(gsel)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            // Starting at 7 makes channel 0 first in line after reset.
            ptr       <= SEL_W'(N_CH - 1);
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_sel   <= gsel;
                ptr       <= gsel;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RR_MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_vld <= 1'b0;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            lock_vld <= !in_last[gsel];
            lock_ch  <= gsel;
            out_last <= in_last[gsel];
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux8to1.sv
module tb_rr_mux8to1;
    import mux_pkg::*;

    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
    logic [N_CH-1:0]       in_last;
    logic                  out_last;
`endif

    int checks   = 0;
    int failures = 0;

    rr_mux8to1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef RR_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [7:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef RR_MUX_PKT_LOCK_EN
        in_last   = '0;
`endif
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%02h exp=00", out_data); end
        checks++;
        if (out_sel !== 3'd0) begin failures++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
        checks++;
        if (in_ready !== 8'h00) begin failures++; $display("FAIL reset_in_ready got=%02h exp=00", in_ready); end
    endtask

    // All channels valid: 0..7 then wrap to 0, one beat every clock.
    task automatic test_round_robin();
        logic [7:0] exp_rdy;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) set_data(i, 8'h10 + 8'(i));
        in_valid = 8'hFF;
        #1;
        checks++;
        if (in_ready !== 8'h01) begin failures++; $display("FAIL rr_first_ready got=%02h exp=01", in_ready); end
        for (int k = 0; k < 9; k++) begin
            tick();
            exp_rdy = 8'h01 << ((k + 1) % 8);
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'(k % 8) || out_data !== 8'h10 + 8'(k % 8))
                begin failures++; $display("FAIL rr_beat%0d got v=%0b sel=%0d d=%02h exp v=1 sel=%0d d=%02h",
                    k, out_valid, out_sel, out_data, k % 8, 8'h10 + 8'(k % 8)); end
            checks++;
            if (in_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready%0d got=%02h exp=%02h", k, in_ready, exp_rdy); end
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_single_channel();
        in_valid = 8'h20;
        set_data(5, 8'hA5);
        #1;
        checks++;
        if (in_ready !== 8'h20) begin failures++; $display("FAIL ch5_ready got=%02h exp=20", in_ready); end
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 3'd5)
            begin failures++; $display("FAIL ch5_beat got v=%0b d=%02h sel=%0d exp v=1 d=a5 sel=5", out_valid, out_data, out_sel); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL ch5_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 8'h02;
        set_data(1, 8'h11);
        #1;
        checks++;
        if (in_ready !== 8'h02) begin failures++; $display("FAIL bp_first_ready got=%02h exp=02", in_ready); end
        tick();
        set_data(1, 8'h22);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 || out_sel !== 3'd1 || in_ready !== 8'h00)
                begin failures++; $display("FAIL bp_hold%0d got v=%0b d=%02h sel=%0d rdy=%02h exp v=1 d=11 sel=1 rdy=00",
                    c, out_valid, out_data, out_sel, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 8'h02) begin failures++; $display("FAIL bp_release_ready got=%02h exp=02", in_ready); end
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22 || out_sel !== 3'd1)
            begin failures++; $display("FAIL bp_next_beat got v=%0b d=%02h sel=%0d exp v=1 d=22 sel=1", out_valid, out_data, out_sel); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_wrap();
        // Park ptr at 6 with a single ch6 beat.
        in_valid = 8'h40;
        set_data(6, 8'h66);
        tick();
        in_valid = 8'h88;
        set_data(3, 8'h33);
        set_data(7, 8'h77);
        #1;
        checks++;
        if (in_ready !== 8'h80) begin failures++; $display("FAIL wrap_p6_ready got=%02h exp=80", in_ready); end
        tick();
        checks++;
        if (out_sel !== 3'd7 || out_data !== 8'h77) begin failures++; $display("FAIL wrap_ch7 got sel=%0d d=%02h exp sel=7 d=77", out_sel, out_data); end
        checks++;
        if (in_ready !== 8'h08) begin failures++; $display("FAIL wrap_p7_ready got=%02h exp=08", in_ready); end
        tick();
        checks++;
        if (out_sel !== 3'd3 || out_data !== 8'h33) begin failures++; $display("FAIL wrap_ch3 got sel=%0d d=%02h exp sel=3 d=33", out_sel, out_data); end
        in_valid = 8'h81;
        set_data(0, 8'h05);
        #1;
        checks++;
        if (in_ready !== 8'h80) begin failures++; $display("FAIL wrap_p3_ready got=%02h exp=80", in_ready); end
        tick();
        checks++;
        if (in_ready !== 8'h01) begin failures++; $display("FAIL wrap_7to0_ready got=%02h exp=01", in_ready); end
        tick();
        in_valid = '0;
        checks++;
        if (out_sel !== 3'd0 || out_data !== 8'h05) begin failures++; $display("FAIL wrap_ch0 got sel=%0d d=%02h exp sel=0 d=05", out_sel, out_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 8'h10;
        set_data(4, 8'h44);
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd4) begin failures++; $display("FAIL rm_held got v=%0b sel=%0d exp v=1 sel=4", out_valid, out_sel); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0)
            begin failures++; $display("FAIL rm_cleared got v=%0b d=%02h sel=%0d exp v=0 d=00 sel=0", out_valid, out_data, out_sel); end
        in_valid = 8'h21;
        set_data(0, 8'h0A);
        #1;
        checks++;
        if (in_ready !== 8'h01) begin failures++; $display("FAIL rm_ready got=%02h exp=01", in_ready); end
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 8'h0A)
            begin failures++; $display("FAIL rm_first_grant got v=%0b sel=%0d d=%02h exp v=1 sel=0 d=0a", out_valid, out_sel, out_data); end
        tick();
    endtask

`ifdef RR_MUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        // ptr is 0 here, so ch2 beats ch4 for the first beat.
        in_valid = 8'h14;
        in_last  = 8'h10;
        set_data(2, 8'h21);
        set_data(4, 8'h41);
        tick();
        checks++;
        if (out_sel !== 3'd2 || out_last !== 1'b0) begin failures++; $display("FAIL lock_b0 got sel=%0d last=%0b exp sel=2 last=0", out_sel, out_last); end
        in_valid = 8'h10;
        #1;
        checks++;
        if (in_ready !== 8'h00) begin failures++; $display("FAIL lock_gap_ready got=%02h exp=00", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL lock_gap_valid got=%0b exp=0", out_valid); end
        in_valid = 8'h14;
        set_data(2, 8'h22);
        tick();
        checks++;
        if (out_sel !== 3'd2 || out_data !== 8'h22) begin failures++; $display("FAIL lock_b1 got sel=%0d d=%02h exp sel=2 d=22", out_sel, out_data); end
        in_last = 8'h14;
        set_data(2, 8'h23);
        tick();
        checks++;
        if (out_sel !== 3'd2 || out_data !== 8'h23 || out_last !== 1'b1)
            begin failures++; $display("FAIL lock_b2 got sel=%0d d=%02h last=%0b exp sel=2 d=23 last=1", out_sel, out_data, out_last); end
        checks++;
        if (in_ready !== 8'h10) begin failures++; $display("FAIL lock_release_ready got=%02h exp=10", in_ready); end
        tick();
        in_valid = '0;
        checks++;
        if (out_sel !== 3'd4 || out_data !== 8'h41) begin failures++; $display("FAIL lock_ch4 got sel=%0d d=%02h exp sel=4 d=41", out_sel, out_data); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single_channel();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef RR_MUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
